uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
// - UART receiver; counterpart of the UART_TX block on the same serial line.
// - Oversamples rx_in by a runtime prescale and deframes start/data/optional parity/stop.
// - Presents the received word with a 1-cycle valid strobe and per-frame error flags.
// - Sits between the pad-side serial input and the parallel consumer in the same clock domain.
// PARAMETERS
// - DATA_WIDTH  8  data bits per frame; sent LSB first
// - PRESC_W     6  width of the prescale input
// PORTS
// - clk         in   1           system clock; all logic on rising edge
// - rst_n       in   1           asynchronous, active-low reset
// - rx_in       in   1           serial input; idles high; asynchronous to clk
// - prescale    in   PRESC_W     clk cycles per bit; legal values 8, 16, 32
// - par_en      in   1           1 = frame carries a parity bit
// - par_typ     in   1           0 = even parity, 1 = odd parity
// - data_out    out  DATA_WIDTH  last good word; held until the next good frame
// - data_valid  out  1           1-cycle pulse: data_out updated
// - par_err     out  1           1-cycle pulse: parity mismatch
// - stp_err     out  1           1-cycle pulse: stop bit sampled 0
// - busy        out  1           high from start-bit detect until frame end
// BEHAVIOUR
// - Reset (async, rst_n=0): FSM=IDLE; counters=0; synchroniser flops=1.
// - Reset values: data_out=0, data_valid=0, par_err=0, stp_err=0, busy=0.
// - Reset mid-frame aborts the frame; no strobe is produced.
// - rx_in passes a 2-flop synchroniser (+2 clk latency); all logic uses the synchronised copy rx_s.
// - Frame-start latch: prescale, par_en and par_typ are latched when a frame starts.
// - Changes to those inputs mid-frame are ignored.
// - prescale < 4 is clamped to 4.
// - Per-bit timing: edge_cnt runs 0..P-1 (P = latched prescale).
// - Each bit is sampled at edge_cnt == P/2 - 1, i.e. mid-bit.
// - FSM states: IDLE, START, DATA, PARITY, STOP.
// - IDLE: on rx_s falling edge (1->0) -> START; busy=1; edge_cnt=0.
// - START: at the sample point: if the sample is 0, continue; otherwise false start -> IDLE.
//   A false start produces no strobe.
// - DATA: DATA_WIDTH bits, LSB first, shifted into a shift register.
//   After the last bit -> PARITY if par_en, else -> STOP.
// - PARITY: the sampled bit is compared with ^data (even) or ~^data (odd) -> STOP.
// - STOP: the sample is evaluated at the stop-bit sample point, then the FSM returns to IDLE.
//   Returning mid-stop allows back-to-back frames.
//   busy drops on the cycle the FSM enters IDLE.
// - Strobes: asserted the cycle after the stop sample point, all at once, each for exactly 1 cycle.
//   - par_err = par_en & mismatch.
//   - stp_err = (stop sample == 0).
//   - data_valid = !par_err & !stp_err.
//   - data_out is loaded in the same cycle as data_valid; an errored frame leaves data_out unchanged.
// - A start edge arriving while not in IDLE is ignored.
// - Line held low (break): one stp_err, then IDLE waits for a 1->0 edge.
// - Latency: data_valid rises sync(2) + (1 + DATA_WIDTH + par_en) * P + P/2 + 1 clk after the start edge.
// CONFIGURATION
// - Macro UART_RX_MAJORITY_EN.
// - Defined: each bit value is the 2-of-3 majority of samples at edge_cnt = P/2-2, P/2-1 and P/2.
//   The decision is taken at P/2; all strobes shift 1 clk later.
// - Undefined: single sample at P/2-1; vote logic is not compiled.
// - Framing, ports and error rules are identical in both builds.
// TESTING
// - P=16, par_en=0, send 8'hA5 -> one data_valid, data_out=8'hA5, no error pulses.
// - P=8, par_en=1, par_typ=0, send 8'h3C with parity bit 1 -> par_err pulse, no data_valid, data_out holds its old value.
// - P=32, par_en=1, par_typ=1, send 8'h01 with stop bit 0 -> stp_err pulse, par_err=0, no data_valid.
// - rx_in low pulse of 3 clk (P=16) -> no strobe, busy falls back to 0, FSM in IDLE.
// - Two back-to-back frames 8'h55, 8'hAA at P=16 -> two data_valid pulses, values in order.
// - rst_n pulsed low during DATA bit 4 -> all outputs 0 immediately; the next full frame 8'hC3 is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : uart_rx
// Desc     : Oversampling UART receiver: start/data/optional parity/stop
//            deframing with a 1-cycle valid strobe and per-frame error pulses.
//            Define UART_RX_MAJORITY_EN for 2-of-3 majority bit sampling.
// Revision : 1.0 - initial release
//==============================================================================
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_in,
    input  logic [PRESC_W-1:0]    prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int                  c_bcnt_w    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_bcnt_w-1:0] c_last_bit  = c_bcnt_w'(DATA_WIDTH - 1);
    localparam logic [PRESC_W-1:0]  c_min_presc = PRESC_W'(4);
    localparam logic [PRESC_W-1:0]  c_one       = PRESC_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                  r_state;
    logic                    r_rx_meta;
    logic                    r_rx_s;
    logic                    r_rx_prev;
    logic [PRESC_W-1:0]      r_presc;
    logic                    r_par_en;
    logic                    r_par_typ;
    logic [PRESC_W-1:0]      r_edge_cnt;
    logic [c_bcnt_w-1:0]     r_bit_cnt;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic                    r_par_bit;

    logic                    w_fall;
    logic [PRESC_W-1:0]      w_presc_in;
    logic [PRESC_W-1:0]      w_half;
    logic                    w_bit_end;
    logic                    w_samp_pt;
    logic                    w_bit;
    logic                    w_par_exp;
    logic                    w_par_bad;
    logic                    w_frame_ok;

    // rx_in is asynchronous; r_rx_prev provides the falling-edge reference
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx_in;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    assign w_fall     = r_rx_prev & ~r_rx_s;
    assign w_presc_in = (prescale < c_min_presc) ? c_min_presc : prescale;
    assign w_half     = {1'b0, r_presc[PRESC_W-1:1]};
    assign w_bit_end  = (r_edge_cnt == (r_presc - c_one));

`ifdef UART_RX_MAJORITY_EN
    localparam logic [PRESC_W-1:0] c_two = PRESC_W'(2);

    logic r_vote0;
    logic r_vote1;

    // Two early samples are held; the third is the live value at the decision point
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vote0 <= 1'b1;
            r_vote1 <= 1'b1;
        end else begin
            if (r_edge_cnt == (w_half - c_two)) begin
                r_vote0 <= r_rx_s;
            end
            if (r_edge_cnt == (w_half - c_one)) begin
                r_vote1 <= r_rx_s;
            end
        end
    end

    assign w_samp_pt = (r_edge_cnt == w_half);
    assign w_bit     = (r_vote0 & r_vote1) | (r_rx_s & (r_vote0 | r_vote1));
`else
    assign w_samp_pt = (r_edge_cnt == (w_half - c_one));
    assign w_bit     = r_rx_s;
`endif

    assign w_par_exp  = r_par_typ ? ~^r_shift : ^r_shift;
    assign w_par_bad  = r_par_en & (r_par_bit != w_par_exp);
    assign w_frame_ok = ~w_par_bad & w_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_presc    <= c_min_presc;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_edge_cnt <= '0;
                    r_bit_cnt  <= '0;
                    if (w_fall) begin
                        r_state   <= S_START;
                        busy      <= 1'b1;
                        r_presc   <= w_presc_in;
                        r_par_en  <= par_en;
                        r_par_typ <= par_typ;
                    end
                end

                S_START: begin
                    if (w_samp_pt && w_bit) begin
                        // Glitch shorter than half a bit: drop it silently
                        r_state    <= S_IDLE;
                        busy       <= 1'b0;
                        r_edge_cnt <= '0;
                    end else if (w_bit_end) begin
                        r_state    <= S_DATA;
                        r_edge_cnt <= '0;
                    end else begin
                        r_edge_cnt <= r_edge_cnt + c_one;
                    end
                end

                S_DATA: begin
                    if (w_samp_pt) begin
                        r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
                    end
                    if (w_bit_end) begin
                        r_edge_cnt <= '0;
                        if (r_bit_cnt == c_last_bit) begin
                            r_bit_cnt <= '0;
                            r_state   <= r_par_en ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_edge_cnt <= r_edge_cnt + c_one;
                    end
                end

                S_PARITY: begin
                    if (w_samp_pt) begin
                        r_par_bit <= w_bit;
                    end
                    if (w_bit_end) begin
                        r_edge_cnt <= '0;
                        r_state    <= S_STOP;
                    end else begin
                        r_edge_cnt <= r_edge_cnt + c_one;
                    end
                end

                S_STOP: begin
                    // Leave at mid-stop so a following start edge is not missed
                    if (w_samp_pt) begin
                        r_state    <= S_IDLE;
                        busy       <= 1'b0;
                        r_edge_cnt <= '0;
                        stp_err    <= ~w_bit;
                        par_err    <= w_par_bad;
                        data_valid <= w_frame_ok;
                        if (w_frame_ok) begin
                            data_out <= r_shift;
                        end
                    end else begin
                        r_edge_cnt <= r_edge_cnt + c_one;
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    busy       <= 1'b0;
                    r_edge_cnt <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : tb_uart_rx
// Desc     : Self-checking bench for uart_rx: vector table, corner sequences
//            and randomized frames against a behavioural frame model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_uart_rx;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          rx_in    = 1'b1;
    logic [PW-1:0] prescale = PW'(16);
    logic          par_en   = 1'b0;
    logic          par_typ  = 1'b0;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;
    logic          busy;

    always #5 clk = ~clk;

    uart_rx #(.DATA_WIDTH(DW), .PRESC_W(PW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_in      (rx_in),
        .prescale   (prescale),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .data_out   (data_out),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .busy       (busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            n_checks = 0;
    int            n_errors = 0;
    int            dv_cnt, pe_cnt, se_cnt, wide_cnt, first_cyc, start_cyc;
    logic          prev_strb;
    logic [DW-1:0] dv_q[$];
    logic [DW-1:0] model_last;

    typedef struct {
        int            presc;
        logic [DW-1:0] data;
        bit            pen;
        bit            ptyp;
        bit            pbit;
        bit            stopb;
        bit            exp_dv;
        bit            exp_pe;
        bit            exp_se;
        logic [DW-1:0] exp_do;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("FAIL %s: actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    // Observes strobes once per cycle on the falling clock edge
    task automatic sample();
        logic s;
        if (!rst_n) begin
            prev_strb = 1'b0;
        end else begin
            s = data_valid | par_err | stp_err;
            if (data_valid) begin
                dv_cnt++;
                dv_q.push_back(data_out);
            end
            if (par_err) pe_cnt++;
            if (stp_err) se_cnt++;
            if (s) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (prev_strb) wide_cnt++;
            end
            prev_strb = s;
        end
    endtask

    task automatic wait_bit(input logic b, input int cycles);
        rx_in = b;
        repeat (cycles) begin
            @(negedge clk);
            sample();
            @(posedge clk);
        end
        #1;
    endtask

    task automatic clear_mon();
        dv_cnt = 0; pe_cnt = 0; se_cnt = 0; wide_cnt = 0; first_cyc = -1;
        prev_strb = 1'b0;
        dv_q.delete();
    endtask

    function automatic int eff_p(input int p);
        return (p < 4) ? 4 : p;
    endfunction

    task automatic send_frame(input int presc_in, input logic [DW-1:0] d, input bit pen,
                              input bit ptyp, input bit pbit, input bit stopb, input bit scramble);
        int p;
        p        = eff_p(presc_in);
        prescale = PW'(presc_in);
        par_en   = pen;
        par_typ  = ptyp;
        start_cyc = cyc;
        wait_bit(1'b0, 4);
        if (scramble) begin
            prescale = PW'($urandom_range(0, 63));
            par_en   = ~pen;
            par_typ  = 1'($urandom);
        end
        if (p > 4) wait_bit(1'b0, p - 4);
        for (int i = 0; i < DW; i++) wait_bit(d[i], p);
        if (pen) wait_bit(pbit, p);
        wait_bit(stopb, p);
        rx_in = 1'b1;
    endtask

    task automatic run_frame(input string name, input int presc_in, input logic [DW-1:0] d,
                             input bit pen, input bit ptyp, input bit pbit, input bit stopb,
                             input bit exp_dv, input bit exp_pe, input bit exp_se,
                             input logic [DW-1:0] exp_do, input bit scramble);
        int p, lat_min;
        p = eff_p(presc_in);
        lat_min = 3 + (1 + DW + int'(pen)) * p + p / 2;
        clear_mon();
        send_frame(presc_in, d, pen, ptyp, pbit, stopb, scramble);
        wait_bit(1'b1, 6);
        chk({name, "_dv"}, dv_cnt, int'(exp_dv));
        chk({name, "_pe"}, pe_cnt, int'(exp_pe));
        chk({name, "_se"}, se_cnt, int'(exp_se));
        chk({name, "_wide"}, wide_cnt, 0);
        chk({name, "_data_out"}, int'(data_out), int'(exp_do));
        chk({name, "_busy_idle"}, int'(busy), 0);
        if (exp_dv && dv_q.size() > 0) chk({name, "_dv_word"}, int'(dv_q[0]), int'(d));
        // Majority build decides one clock later
        if (exp_dv | exp_pe | exp_se)
            chk_range({name, "_latency"}, first_cyc - start_cyc, lat_min, lat_min + 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int ones, p_sel, pres;
        bit pen, ptyp, badp, stopb, pbit, exp_pe, exp_se, exp_dv;
        logic [DW-1:0] d;
        int w0, w1;

        clear_mon();
        vecs[0] = '{16, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[1] = '{ 8, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5};
        vecs[2] = '{32, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
        vecs[3] = '{16, 8'h7E, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h7E};
        vecs[4] = '{ 8, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[5] = '{32, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00};
        vecs[6] = '{ 2, 8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h96};
        vecs[7] = '{16, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h80};
        vecs[8] = '{ 8, 8'h0F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h80};

        // Reset state
        #1;
        wait_bit(1'b1, 4);
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_dv", int'(data_valid), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        wait_bit(1'b1, 4);
        chk("post_rst_strobes", int'({data_valid, par_err, stp_err}), 0);
        chk("post_rst_busy", int'(busy), 0);

        for (int i = 0; i < 9; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].presc, vecs[i].data, vecs[i].pen,
                      vecs[i].ptyp, vecs[i].pbit, vecs[i].stopb, vecs[i].exp_dv,
                      vecs[i].exp_pe, vecs[i].exp_se, vecs[i].exp_do, 1'b0);
        end
        model_last = 8'h80;

        // False start: 3-clock low pulse
        clear_mon();
        prescale = PW'(16); par_en = 1'b0;
        wait_bit(1'b0, 3);
        wait_bit(1'b1, 2);
        chk("glitch_busy_high", int'(busy), 1);
        wait_bit(1'b1, 30);
        chk("glitch_busy_low", int'(busy), 0);
        chk("glitch_strobes", dv_cnt + pe_cnt + se_cnt, 0);

        // Back-to-back frames
        clear_mon();
        send_frame(16, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(16, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_bit(1'b1, 20);
        w0 = (dv_q.size() > 0) ? int'(dv_q[0]) : -1;
        w1 = (dv_q.size() > 1) ? int'(dv_q[1]) : -1;
        chk("b2b_dv_count", dv_cnt, 2);
        chk("b2b_word0", w0, 'h55);
        chk("b2b_word1", w1, 'hAA);
        chk("b2b_errors", pe_cnt + se_cnt, 0);
        model_last = 8'hAA;

        // Line break: one stop error, then wait for a real edge
        clear_mon();
        prescale = PW'(16); par_en = 1'b0;
        wait_bit(1'b0, 16 * 14);
        chk("break_se", se_cnt, 1);
        chk("break_dv", dv_cnt, 0);
        chk("break_busy", int'(busy), 0);
        wait_bit(1'b1, 20);
        chk("break_se_after", se_cnt, 1);
        chk("break_data_out", int'(data_out), int'(model_last));

        // Reset during data bit 4
        clear_mon();
        prescale = PW'(16); par_en = 1'b0;
        d = 8'h5A;
        wait_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) wait_bit(d[i], 16);
        wait_bit(d[4], 8);
        chk("midrst_busy_before", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_data_out", int'(data_out), 0);
        chk("midrst_strobes", int'({data_valid, par_err, stp_err}), 0);
        chk("midrst_busy", int'(busy), 0);
        wait_bit(1'b1, 3);
        rst_n = 1'b1;
        wait_bit(1'b1, 10);
        chk("midrst_no_strobe", dv_cnt + pe_cnt + se_cnt, 0);
        run_frame("after_rst", 16, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC3, 1'b0);
        model_last = 8'hC3;

        // Randomized frames against the frame-level model
        for (int k = 0; k < 40; k++) begin
            p_sel = $urandom_range(0, 9);
            case (p_sel % 3)
                0:       pres = 8;
                1:       pres = 16;
                default: pres = 32;
            endcase
            if (p_sel == 9) pres = $urandom_range(0, 3);
            d     = DW'($urandom);
            pen   = 1'($urandom);
            ptyp  = 1'($urandom);
            badp  = ($urandom_range(0, 7) == 0);
            stopb = ($urandom_range(0, 7) != 0);
            ones = 0;
            for (int b = 0; b < DW; b++) ones += int'(d[b]);
            pbit   = 1'(((ones % 2) != 0) ^ ptyp ^ badp);
            exp_pe = pen && (((ones + int'(pbit)) % 2) != int'(ptyp));
            exp_se = !stopb;
            exp_dv = !exp_pe && !exp_se;
            if (exp_dv) model_last = d;
            run_frame($sformatf("rnd%0d", k), pres, d, pen, ptyp, pbit, stopb,
                      exp_dv, exp_pe, exp_se, model_last, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
